cmd_loader: RTL and testbench

- Streaming parser for TRS-80 /CMD program images delivered over the hps_io ioctl download channel.
- Decodes load, transfer and skip records, then issues byte writes into system RAM through a valid/ready memory port, throttling the HPS with ioctl_wait.
- Reports the program entry address and load status to the machine core.
- Replaces the ad-hoc loader process in the top level; sits between hps_io and the core's RAM write mux.

---
 rtl/cmd_loader_if.sv | 29 ++
 rtl/cmd_loader.sv | 183 ++++++++++++++++++
 tb/tb_cmd_loader.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_loader_if.sv
// Bundle of the hps_io ioctl download channel, the RAM write port and loader status.
// The loader side uses the slave modport; the hps_io/core side uses master.
interface cmd_loader_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              ioctl_download;
  logic [7:0]        ioctl_index;
  logic              ioctl_wr;
  logic [7:0]        ioctl_data;
  logic              ioctl_wait;
  logic              mem_wr;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic [15:0]       entry_addr;
  logic              entry_valid;
  logic              busy;
  logic              error;

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_data, mem_ready,
    output ioctl_wait, mem_wr, mem_addr, mem_data, entry_addr, entry_valid, busy, error
  );

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_data, mem_ready,
    input  ioctl_wait, mem_wr, mem_addr, mem_data, entry_addr, entry_valid, busy, error
  );
endinterface

// File: rtl/cmd_loader.sv
// Streaming TRS-80 /CMD image parser: turns ioctl download bytes into RAM writes and an entry address.
// Optional CPU autostart handshake (start_req/start_ack) is enabled by defining CMD_LOADER_AUTOSTART_EN.
module cmd_loader #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned INDEX       = 2,
  parameter int unsigned BASE_OFFSET = 0
) (
  input  logic clk_sys,
  input  logic reset,
`ifdef CMD_LOADER_AUTOSTART_EN
  output logic start_req,
  input  logic start_ack,
`endif
  cmd_loader_if.slave bus
);

  localparam int unsigned CNT_W = 9;

  typedef enum logic [2:0] {
    S_IDLE, S_GET_TYPE, S_GET_LEN, S_ADDR_LO, S_ADDR_HI, S_DATA, S_SKIP, S_DONE
  } state_t;

  typedef enum logic [1:0] { M_LOAD, M_XFER, M_SKIP } mode_t;

  state_t            state_q;
  mode_t             mode_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [7:0]        addr_lo_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              dl_q;
  logic              mem_wr_q;
  logic              first_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_data_q;
  logic [15:0]       entry_addr_q;
  logic              entry_valid_q;
  logic              busy_q;
  logic              error_q;

  logic              wait_c;
  logic              start_c;
  logic              fall_c;
  logic              strobe_c;
  logic [CNT_W-1:0]  load_cnt_c;
  logic [ADDR_W-1:0] load_ptr_c;

  // Stall while a write is unaccepted, and always for the first cycle of a freshly issued write.
  assign wait_c   = mem_wr_q & (~bus.mem_ready | first_q);
  assign start_c  = bus.ioctl_download & ~dl_q & (bus.ioctl_index == 8'(INDEX));
  assign fall_c   = dl_q & ~bus.ioctl_download & (state_q != S_IDLE);
  assign strobe_c = bus.ioctl_wr & ~wait_c & (state_q != S_IDLE) & ~fall_c;

  assign load_ptr_c = ADDR_W'({bus.ioctl_data, addr_lo_q}) + ADDR_W'(BASE_OFFSET);

  // Data bytes after the two address bytes; lengths 0..2 encode 256..258 payload bytes.
  always_comb begin
    load_cnt_c = CNT_W'(bus.ioctl_data) - CNT_W'(2);
    if (bus.ioctl_data == 8'd0)
      load_cnt_c = CNT_W'(254);
    else if (bus.ioctl_data <= 8'd2)
      load_cnt_c = CNT_W'(bus.ioctl_data) + CNT_W'(254);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      mode_q        <= M_LOAD;
      cnt_q         <= '0;
      addr_lo_q     <= '0;
      ptr_q         <= '0;
      dl_q          <= 1'b0;
      mem_wr_q      <= 1'b0;
      first_q       <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_q    <= '0;
      entry_addr_q  <= '0;
      entry_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      dl_q    <= bus.ioctl_download;
      first_q <= 1'b0;
      if (mem_wr_q && bus.mem_ready)
        mem_wr_q <= 1'b0;
      if (bus.ioctl_wr && wait_c)
        error_q <= 1'b1;
      // Busy lingers after the download ends until any outstanding write is accepted.
      if (state_q == S_IDLE && busy_q && (!mem_wr_q || bus.mem_ready))
        busy_q <= 1'b0;

      if (start_c) begin
        state_q       <= S_GET_TYPE;
        busy_q        <= 1'b1;
        error_q       <= 1'b0;
        entry_valid_q <= 1'b0;
      end else if (fall_c) begin
        if (state_q != S_GET_TYPE && state_q != S_DONE)
          error_q <= 1'b1;
        state_q <= S_IDLE;
        busy_q  <= mem_wr_q & ~bus.mem_ready;
      end else if (strobe_c) begin
        case (state_q)
          S_GET_TYPE: begin
            if (bus.ioctl_data == 8'h01)      mode_q <= M_LOAD;
            else if (bus.ioctl_data == 8'h02) mode_q <= M_XFER;
            else                              mode_q <= M_SKIP;
            state_q <= S_GET_LEN;
          end
          S_GET_LEN: begin
            if (mode_q == M_SKIP) begin
              cnt_q   <= (bus.ioctl_data == 8'd0) ? CNT_W'(256) : CNT_W'(bus.ioctl_data);
              state_q <= S_SKIP;
            end else begin
              cnt_q   <= load_cnt_c;
              state_q <= S_ADDR_LO;
            end
          end
          S_ADDR_LO: begin
            addr_lo_q <= bus.ioctl_data;
            state_q   <= S_ADDR_HI;
          end
          S_ADDR_HI: begin
            if (mode_q == M_XFER) begin
              entry_addr_q  <= {bus.ioctl_data, addr_lo_q};
              entry_valid_q <= 1'b1;
              state_q       <= S_DONE;
            end else begin
              ptr_q   <= load_ptr_c;
              state_q <= (cnt_q == '0) ? S_GET_TYPE : S_DATA;
            end
          end
          S_DATA: begin
            mem_wr_q   <= 1'b1;
            first_q    <= 1'b1;
            mem_addr_q <= ptr_q;
            mem_data_q <= bus.ioctl_data;
            ptr_q      <= ptr_q + ADDR_W'(1);
            cnt_q      <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1))
              state_q <= S_GET_TYPE;
          end
          S_SKIP: begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1))
              state_q <= S_GET_TYPE;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.ioctl_wait  = wait_c;
  assign bus.mem_wr      = mem_wr_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_data    = mem_data_q;
  assign bus.entry_addr  = entry_addr_q;
  assign bus.entry_valid = entry_valid_q;
  assign bus.busy        = busy_q;
  assign bus.error       = error_q;

`ifdef CMD_LOADER_AUTOSTART_EN
  logic busy_prev_q;
  logic start_req_q;

  // Request a CPU jump once a clean download with a transfer record has fully retired.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      busy_prev_q <= 1'b0;
      start_req_q <= 1'b0;
    end else begin
      busy_prev_q <= busy_q;
      if (busy_prev_q && !busy_q && entry_valid_q && !error_q)
        start_req_q <= 1'b1;
      else if (start_ack)
        start_req_q <= 1'b0;
    end
  end

  assign start_req = start_req_q;
`endif

endmodule

// File: tb/tb_cmd_loader.sv
// Directed bench for cmd_loader: table of /CMD streams plus hand-written stall, bulk, error and reset cases.
module tb_cmd_loader;

  logic clk;
  logic rst;

  cmd_loader_if #(.ADDR_W(16)) if0 ();
  cmd_loader_if #(.ADDR_W(16)) if1 ();

  assign if1.ioctl_download = if0.ioctl_download;
  assign if1.ioctl_index    = if0.ioctl_index;
  assign if1.ioctl_wr       = if0.ioctl_wr;
  assign if1.ioctl_data     = if0.ioctl_data;
  assign if1.mem_ready      = if0.mem_ready;

`ifdef CMD_LOADER_AUTOSTART_EN
  logic sr0, sr1, ack;
`endif

  cmd_loader #(.ADDR_W(16), .INDEX(2), .BASE_OFFSET(0)) dut0 (
    .clk_sys (clk),
    .reset   (rst),
`ifdef CMD_LOADER_AUTOSTART_EN
    .start_req (sr0),
    .start_ack (ack),
`endif
    .bus     (if0)
  );

  cmd_loader #(.ADDR_W(16), .INDEX(2), .BASE_OFFSET(2)) dut1 (
    .clk_sys (clk),
    .reset   (rst),
`ifdef CMD_LOADER_AUTOSTART_EN
    .start_req (sr1),
    .start_ack (1'b0),
`endif
    .bus     (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [15:0] a; logic [7:0] d; } wr_t;
  wr_t log0[$];
  wr_t log1[$];

  always @(posedge clk) begin
    if (if0.mem_wr && if0.mem_ready) log0.push_back({if0.mem_addr, if0.mem_data});
    if (if1.mem_wr && if1.mem_ready) log1.push_back({if1.mem_addr, if1.mem_data});
  end

  typedef struct {
    int            n;
    logic [127:0]  b;      // stream bytes, first byte most significant
    bit            sel1;   // check the BASE_OFFSET=2 instance
    int            nwr;
    logic [3:0][23:0] w;   // expected writes {addr,data}, w[0] first
    bit            ev;
    logic [15:0]   entry;
    bit            err;
  } vec_t;

  vec_t vt [5];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timeout", nm);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    while (if0.ioctl_wait && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) timeout("send wait");
    if0.ioctl_wr   = 1'b1;
    if0.ioctl_data = b;
    @(posedge clk);
    #1 if0.ioctl_wr = 1'b0;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    @(negedge clk);
    if0.ioctl_index    = idx;
    if0.ioctl_download = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic end_dl();
    int t = 0;
    @(negedge clk);
    if0.ioctl_download = 1'b0;
    @(negedge clk);
    while ((if0.busy || if1.busy) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) timeout("busy drop");
    repeat (2) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input int k);
    log0.delete();
    log1.delete();
    start_dl(8'd2);
    for (int i = 0; i < v.n; i++) send_byte(v.b[8*(v.n-1-i) +: 8]);
    end_dl();
    if (v.sel1) begin
      chk($sformatf("v%0d nwr", k), 32'(log1.size()), 32'(v.nwr));
      for (int j = 0; j < v.nwr; j++)
        chk($sformatf("v%0d wr%0d", k, j), (j < log1.size()) ? 32'(log1[j]) : 32'hDEAD, 32'(v.w[j]));
      chk($sformatf("v%0d entry_valid", k), 32'(if1.entry_valid), 32'(v.ev));
      if (v.ev) chk($sformatf("v%0d entry", k), 32'(if1.entry_addr), 32'(v.entry));
      chk($sformatf("v%0d error", k), 32'(if1.error), 32'(v.err));
      chk($sformatf("v%0d busy", k), 32'(if1.busy), 32'd0);
    end else begin
      chk($sformatf("v%0d nwr", k), 32'(log0.size()), 32'(v.nwr));
      for (int j = 0; j < v.nwr; j++)
        chk($sformatf("v%0d wr%0d", k, j), (j < log0.size()) ? 32'(log0[j]) : 32'hDEAD, 32'(v.w[j]));
      chk($sformatf("v%0d entry_valid", k), 32'(if0.entry_valid), 32'(v.ev));
      if (v.ev) chk($sformatf("v%0d entry", k), 32'(if0.entry_addr), 32'(v.entry));
      chk($sformatf("v%0d error", k), 32'(if0.error), 32'(v.err));
      chk($sformatf("v%0d busy", k), 32'(if0.busy), 32'd0);
    end
  endtask

  initial begin
    vt[0] = '{n: 11, b: 128'({8'h01,8'h05,8'h00,8'h40,8'hAA,8'hBB,8'hCC,8'h02,8'h02,8'h00,8'h52}),
              sel1: 0, nwr: 3, w: {24'h0, 24'h4002CC, 24'h4001BB, 24'h4000AA},
              ev: 1, entry: 16'h5200, err: 0};
    vt[1] = '{n: 5, b: 128'({8'h01,8'h06,8'h00,8'h40,8'hAA}),
              sel1: 0, nwr: 1, w: {24'h0, 24'h0, 24'h0, 24'h4000AA},
              ev: 0, entry: 16'h0, err: 1};
    vt[2] = '{n: 14, b: 128'({8'h05,8'h03,8'h41,8'h42,8'h43,8'h01,8'h03,8'hFF,8'hFF,8'h11,8'h02,8'h02,8'h34,8'h12}),
              sel1: 1, nwr: 1, w: {24'h0, 24'h0, 24'h0, 24'h000111},
              ev: 1, entry: 16'h1234, err: 0};
    vt[3] = '{n: 6, b: 128'({8'h01,8'h04,8'hFF,8'hFF,8'h01,8'h02}),
              sel1: 0, nwr: 2, w: {24'h0, 24'h0, 24'h000002, 24'hFFFF01},
              ev: 0, entry: 16'h0, err: 0};
    vt[4] = '{n: 9, b: 128'({8'h02,8'h02,8'h00,8'h52,8'h01,8'h05,8'h00,8'h40,8'hAA}),
              sel1: 0, nwr: 0, w: '0,
              ev: 1, entry: 16'h5200, err: 0};

    rst = 1'b1;
    if0.ioctl_download = 1'b0;
    if0.ioctl_index    = 8'd0;
    if0.ioctl_wr       = 1'b0;
    if0.ioctl_data     = 8'd0;
    if0.mem_ready      = 1'b1;
`ifdef CMD_LOADER_AUTOSTART_EN
    ack = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst mem_wr", 32'(if0.mem_wr), 32'd0);
    chk("rst busy", 32'(if0.busy), 32'd0);
    chk("rst error", 32'(if0.error), 32'd0);
    chk("rst entry_valid", 32'(if0.entry_valid), 32'd0);
    chk("rst entry_addr", 32'(if0.entry_addr), 32'd0);
    chk("rst wait", 32'(if0.ioctl_wait), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 5; k++) run_vec(vt[k], k);

    // Write stalled for five cycles on the second data byte.
    log0.delete();
    start_dl(8'd2);
    send_byte(8'h01); send_byte(8'h05); send_byte(8'h00); send_byte(8'h40); send_byte(8'hAA);
    repeat (2) @(negedge clk);
    if0.mem_ready  = 1'b0;
    if0.ioctl_wr   = 1'b1;
    if0.ioctl_data = 8'hBB;
    @(posedge clk);
    #1 if0.ioctl_wr = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("stall%0d wait", c), 32'(if0.ioctl_wait), 32'd1);
      chk($sformatf("stall%0d addr", c), 32'(if0.mem_addr), 32'h4001);
      chk($sformatf("stall%0d mem_wr", c), 32'(if0.mem_wr), 32'd1);
    end
    chk("stall nwr mid", 32'(log0.size()), 32'd1);
    if0.mem_ready = 1'b1;
    send_byte(8'hCC);
    send_byte(8'h02); send_byte(8'h02); send_byte(8'h00); send_byte(8'h52);
    end_dl();
    chk("stall nwr", 32'(log0.size()), 32'd3);
    if (log0.size() == 3) begin
      chk("stall wr0", 32'(log0[0]), 32'h4000AA);
      chk("stall wr1", 32'(log0[1]), 32'h4001BB);
      chk("stall wr2", 32'(log0[2]), 32'h4002CC);
    end
    chk("stall entry", 32'(if0.entry_addr), 32'h5200);
    chk("stall error", 32'(if0.error), 32'd0);

    // Length byte 0: 254 data bytes.
    log0.delete();
    start_dl(8'd2);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h80);
    for (int i = 0; i < 254; i++) send_byte(8'(i));
    send_byte(8'h02); send_byte(8'h02); send_byte(8'h00); send_byte(8'h80);
    end_dl();
    chk("bulk nwr", 32'(log0.size()), 32'd254);
    begin
      int errs = 0;
      for (int i = 0; i < 254 && i < log0.size(); i++)
        if (log0[i] !== {16'(16'h8000 + i), 8'(i)}) errs++;
      chk("bulk data", 32'(errs), 32'd0);
    end
    chk("bulk entry", 32'(if0.entry_addr), 32'h8000);
    chk("bulk entry_valid", 32'(if0.entry_valid), 32'd1);

    // Other index: loader stays idle.
    log0.delete();
    start_dl(8'd1);
    send_byte(8'h01); send_byte(8'h05); send_byte(8'h00); send_byte(8'h40); send_byte(8'hAA);
    @(negedge clk);
    chk("idx busy", 32'(if0.busy), 32'd0);
    chk("idx wait", 32'(if0.ioctl_wait), 32'd0);
    end_dl();
    chk("idx nwr", 32'(log0.size()), 32'd0);

    // Strobe while stalled is dropped and flags error.
    log0.delete();
    start_dl(8'd2);
    send_byte(8'h01); send_byte(8'h04); send_byte(8'h00); send_byte(8'h30);
    @(negedge clk);
    if0.mem_ready = 1'b0;
    send_byte(8'h11);
    @(negedge clk);
    chk("drop wait", 32'(if0.ioctl_wait), 32'd1);
    if0.ioctl_wr   = 1'b1;
    if0.ioctl_data = 8'h22;
    @(posedge clk);
    #1 if0.ioctl_wr = 1'b0;
    @(negedge clk);
    chk("drop error", 32'(if0.error), 32'd1);
    if0.mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("drop nwr", 32'(log0.size()), 32'd1);
    if (log0.size() == 1) chk("drop wr0", 32'(log0[0]), 32'h300011);
    end_dl();

`ifdef CMD_LOADER_AUTOSTART_EN
    run_vec(vt[0], 10);
    chk("autostart req", 32'(sr0), 32'd1);
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("autostart ack", 32'(sr0), 32'd0);
`endif

    // Reset during a stalled write clears outputs without waiting for a clock edge.
    start_dl(8'd2);
    send_byte(8'h01); send_byte(8'h05); send_byte(8'h00); send_byte(8'h40);
    @(negedge clk);
    if0.mem_ready = 1'b0;
    send_byte(8'hAA);
    @(negedge clk);
    chk("pre-rst mem_wr", 32'(if0.mem_wr), 32'd1);
    #1 rst = 1'b1;
    if0.ioctl_download = 1'b0;
    #1;
    chk("arst mem_wr", 32'(if0.mem_wr), 32'd0);
    chk("arst busy", 32'(if0.busy), 32'd0);
    chk("arst wait", 32'(if0.ioctl_wait), 32'd0);
    chk("arst mem_addr", 32'(if0.mem_addr), 32'd0);
    chk("arst mem_data", 32'(if0.mem_data), 32'd0);
    chk("arst entry_valid", 32'(if0.entry_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    if0.mem_ready = 1'b1;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
